linebuf_scheduler: RTL and testbench

Sequences the off-screen line buffer's draw-side write port (128-bit words, 16 × 8-bit palette indices per word) for the double-buffered scanline renderer. On every line start it flips the buffer select, clears the newly off-screen buffer to a background colour, then shares the write port between two draw requesters with round-robin arbitration until the next line start. It sits between the draw engines (tile = requester 0, sprite = requester 1) and the double buffer's `addr_off_draw`/`we_off_draw`/`colour_off_draw` port.

---
 rtl/vdp_pkg.sv | 7 +
 rtl/linebuf_scheduler_if.sv | 11 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/linebuf_scheduler.sv | 84 ++++++++
 tb/tb_linebuf_scheduler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/vdp_pkg.sv
// vdp_pkg: shared types and sizes for the line-buffer draw-side scheduler
package vdp_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, GRANT} lb_state_t;
  localparam int LB_ADDRW = 7;
  localparam int LB_LANES = 16;
  localparam int LB_WORDW = 128;
endpackage

// File: rtl/linebuf_scheduler_if.sv
// linebuf_scheduler_if: two-requester write-request bundle (tile = 0, sprite = 1)
interface linebuf_scheduler_if #(parameter int ADDRW = vdp_pkg::LB_ADDRW);
  import vdp_pkg::*;
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][ADDRW-1:0]      req_addr;
  logic [1:0][LB_LANES-1:0]   req_we;
  logic [1:0][LB_WORDW-1:0]   req_colour;
  modport master (output req_valid, req_addr, req_we, req_colour, input req_ready);
  modport slave  (input req_valid, req_addr, req_we, req_colour, output req_ready);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; a tie goes to the requester not served last
module rr_arbiter2 (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  // one-hot grant; pointer moves only when a transfer actually happens
  always_comb begin
    gnt_o  = !en_i ? 2'b00 : (req_i == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_i;
    last_d = upd_i ? gnt_o[1] : last_q;
  end
  // last-served pointer starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) last_q <= 1'b1;
    else          last_q <= last_d;
  end
endmodule

// File: rtl/linebuf_scheduler.sv
// linebuf_scheduler: flips the line buffer, clears the off-screen half, then arbitrates draw writes
module linebuf_scheduler
  import vdp_pkg::*;
#(
  parameter int CLEAR_WORDS = 80,
  parameter int ADDRW       = LB_ADDRW
) (
  input  logic                 clk_pix,
  input  logic                 rst_pix,
  input  logic                 line_start_i,
  input  logic [7:0]           bg_colour_i,
  linebuf_scheduler_if.slave   req,
  output logic                 buffsel_o,
  output logic [ADDRW-1:0]     addr_off_draw_o,
  output logic [LB_LANES-1:0]  we_off_draw_o,
  output logic [LB_WORDW-1:0]  colour_off_draw_o,
  output logic                 busy_o,
  output logic                 overrun_o
);
  localparam logic [ADDRW:0] LAST = (ADDRW+1)'(CLEAR_WORDS - 1);
  lb_state_t             state_q, state_d;
  logic [ADDRW:0]        cnt_q, cnt_d;
  logic                  buffsel_q, buffsel_d;
  logic [ADDRW-1:0]      addr_q, addr_d;
  logic [LB_LANES-1:0]   we_q, we_d;
  logic [LB_WORDW-1:0]   colour_q, colour_d;
  logic                  overrun_q, overrun_d;
  logic [1:0]            gnt;
  logic                  clr_wr, xfer, sel, arb_en;

  assign arb_en        = state_q == GRANT && !line_start_i;
  assign req.req_ready = gnt;

  rr_arbiter2 u_arb (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .req_i   (req.req_valid),
    .en_i    (arb_en),
    .upd_i   (xfer),
    .gnt_o   (gnt)
  );

  // next state and port data; line_start pre-empts both clearing and granting
  always_comb begin
    clr_wr    = state_q == CLEAR && !line_start_i;
    xfer      = |gnt;
    sel       = gnt[1];
    state_d   = line_start_i ? CLEAR : (state_q == CLEAR && cnt_q == LAST) ? GRANT : state_q;
    cnt_d     = line_start_i ? '0 : clr_wr ? cnt_q + 1'b1 : cnt_q;
    buffsel_d = buffsel_q ^ line_start_i;
    overrun_d = line_start_i && state_q == CLEAR;
    addr_d    = clr_wr ? cnt_q[ADDRW-1:0] : xfer ? req.req_addr[sel] : addr_q;
    we_d      = clr_wr ? '1 : xfer ? req.req_we[sel] : '0;
    colour_d  = clr_wr ? {(LB_WORDW/8){bg_colour_i}} : xfer ? req.req_colour[sel] : colour_q;
  end

  // state and registered write port; reset aborts any clear or transfer in flight
  always_ff @(posedge clk_pix) begin
    if (!rst_pix) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buffsel_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= '0;
      colour_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buffsel_q <= buffsel_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      colour_q  <= colour_d;
      overrun_q <= overrun_d;
    end
  end

  assign buffsel_o         = buffsel_q;
  assign addr_off_draw_o   = addr_q;
  assign we_off_draw_o     = we_q;
  assign colour_off_draw_o = colour_q;
  assign busy_o            = state_q == CLEAR;
  assign overrun_o         = overrun_q;
endmodule

// File: tb/tb_linebuf_scheduler.sv
// tb_linebuf_scheduler: directed checks of clear, arbitration, overrun and reset behaviour
module tb_linebuf_scheduler;
  localparam int CW = 80;
  localparam int AW = 7;
  localparam logic [127:0] COL_A = {4{32'h0a0b0c0d}};
  localparam logic [127:0] COL_B = {4{32'h11223344}};

  logic           clk_pix = 1'b0;
  logic           rst_pix = 1'b0;
  logic           line_start = 1'b0;
  logic [7:0]     bg = 8'h00;
  logic           buffsel, busy, overrun;
  logic [AW-1:0]  addr;
  logic [15:0]    we;
  logic [127:0]   colour;
  int             n_chk = 0;
  int             n_fail = 0;

  linebuf_scheduler_if #(.ADDRW(AW)) rq ();

  linebuf_scheduler #(.CLEAR_WORDS(CW), .ADDRW(AW)) dut (
    .clk_pix           (clk_pix),
    .rst_pix           (rst_pix),
    .line_start_i      (line_start),
    .bg_colour_i       (bg),
    .req               (rq.slave),
    .buffsel_o         (buffsel),
    .addr_off_draw_o   (addr),
    .we_off_draw_o     (we),
    .colour_off_draw_o (colour),
    .busy_o            (busy),
    .overrun_o         (overrun)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_pix);
    #2;
  endtask

  task automatic run_clear(input logic [7:0] c);
    for (int k = 0; k < CW; k++) begin
      step();
      check("clr_addr", addr, k);
      check("clr_we", we, 16'hffff);
      check("clr_col", colour, {16{c}});
      check("clr_busy", busy, k < CW - 1);
      check("clr_ovr", overrun, 1'b0);
      if (k < CW - 1) check("clr_ready", rq.req_ready, 2'b00);
    end
  endtask

  initial begin
    rq.req_valid     = 2'b11;
    rq.req_addr[0]   = 7'd5;
    rq.req_addr[1]   = 7'd9;
    rq.req_we[0]     = 16'h000f;
    rq.req_we[1]     = 16'hf000;
    rq.req_colour[0] = COL_A;
    rq.req_colour[1] = COL_B;
    repeat (3) step();
    rst_pix = 1'b1;
    #1;
    check("rst_bs", buffsel, 1'b0);
    check("rst_we", we, 16'h0);
    check("rst_addr", addr, 7'd0);
    check("rst_col", colour, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_ready", rq.req_ready, 2'b00);
    repeat (5) begin
      step();
      check("idle_ready", rq.req_ready, 2'b00);
      check("idle_we", we, 16'h0);
      check("idle_bs", buffsel, 1'b0);
    end

    bg = 8'h2a;
    line_start = 1'b1;
    #1;
    check("ls_ready", rq.req_ready, 2'b00);
    step();
    line_start = 1'b0;
    #1;
    check("ls1_bs", buffsel, 1'b1);
    check("ls1_busy", busy, 1'b1);
    check("ls1_we", we, 16'h0);
    run_clear(8'h2a);
    check("gnt_first", rq.req_ready, 2'b01);
    for (int j = 1; j <= 6; j++) begin
      step();
      check("arb_addr", addr, (j % 2) ? 7'd5 : 7'd9);
      check("arb_we", we, (j % 2) ? 16'h000f : 16'hf000);
      check("arb_ready", rq.req_ready, (j % 2) ? 2'b10 : 2'b01);
    end
    step();
    rq.req_valid = 2'b10;
    #1;
    check("solo_prev", addr, 7'd5);
    check("solo_ready", rq.req_ready, 2'b10);
    repeat (3) begin
      step();
      check("solo_addr", addr, 7'd9);
      check("solo_we", we, 16'hf000);
      check("solo_col", colour, COL_B);
      check("solo_ready2", rq.req_ready, 2'b10);
    end
    rq.req_valid = 2'b00;
    step();
    step();
    check("nowr_we", we, 16'h0);
    check("nowr_addr", addr, 7'd9);
    check("nowr_col", colour, COL_B);

    rq.req_valid = 2'b01;
    bg = 8'hc3;
    line_start = 1'b1;
    #1;
    check("lsg_ready", rq.req_ready, 2'b00);
    step();
    line_start = 1'b0;
    #1;
    check("lsg_bs", buffsel, 1'b0);
    check("lsg_busy", busy, 1'b1);
    check("lsg_we", we, 16'h0);
    run_clear(8'hc3);
    check("lsg_gnt", rq.req_ready, 2'b01);
    step();
    check("lsg_addr", addr, 7'd5);
    check("lsg_wr_we", we, 16'h000f);
    check("lsg_col", colour, COL_A);

    rq.req_valid = 2'b00;
    bg = 8'h5e;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    #1;
    check("ov1_ovr", overrun, 1'b0);
    check("ov1_bs", buffsel, 1'b1);
    repeat (39) step();
    check("ov_mid_addr", addr, 7'd38);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    #1;
    check("ov_pulse", overrun, 1'b1);
    check("ov_bs", buffsel, 1'b0);
    check("ov_we", we, 16'h0);
    check("ov_busy", busy, 1'b1);
    run_clear(8'h5e);

    rq.req_valid = 2'b01;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    #1;
    check("rc_bs1", buffsel, 1'b1);
    repeat (31) step();
    check("rc_addr30", addr, 7'd30);
    check("rc_we30", we, 16'hffff);
    rst_pix = 1'b0;
    step();
    check("rc_we", we, 16'h0);
    check("rc_busy", busy, 1'b0);
    check("rc_bs", buffsel, 1'b0);
    check("rc_addr", addr, 7'd0);
    check("rc_ready", rq.req_ready, 2'b00);
    rst_pix = 1'b1;
    repeat (3) begin
      step();
      check("rc_idle_we", we, 16'h0);
      check("rc_idle_busy", busy, 1'b0);
      check("rc_idle_ready", rq.req_ready, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
